// File: rtl/seg7_count_monitor.sv
// rtl/seg7_count_monitor.sv - receive-side checker for the multiplexed 7-segment countdown display
// Defining SEG7_MON_ERR_CLR_EN adds the err_clr input that clears the sticky flags.
module seg7_count_monitor #(
  parameter bit SEG_ACTIVE_LOW = 1'b0,
  parameter int STABLE_FRAMES  = 2
) (
  input  logic       clkIn,
  input  logic       rst,
  input  logic [6:0] seg,
  input  logic       dig_sel,
  input  logic       seg_valid,
`ifdef SEG7_MON_ERR_CLR_EN
  input  logic       err_clr,
`endif
  output logic [7:0] bcd,
  output logic       value_vld,
  output logic       zero,
  output logic       seq_err,
  output logic       bad_glyph
);

  typedef enum logic [1:0] {EMPTY, TRACK, DONE} state_t;

  typedef struct packed {
    logic       invalid;
    logic       blank;
    logic [3:0] digit;
  } glyph_t;

  localparam logic [3:0] STAB_MAX = 4'(STABLE_FRAMES);

  function automatic glyph_t decode(input logic [6:0] p);
    glyph_t g;
    g = '0;
    case (p)
      7'h3F:   g.digit = 4'd0;
      7'h06:   g.digit = 4'd1;
      7'h5B:   g.digit = 4'd2;
      7'h4F:   g.digit = 4'd3;
      7'h66:   g.digit = 4'd4;
      7'h6D:   g.digit = 4'd5;
      7'h7D:   g.digit = 4'd6;
      7'h07:   g.digit = 4'd7;
      7'h7F:   g.digit = 4'd8;
      7'h6F:   g.digit = 4'd9;
      7'h00:   g.blank = 1'b1;
      default: g.invalid = 1'b1;
    endcase
    return g;
  endfunction

  // BCD minus one with a tens borrow; only used for values above 00
  function automatic logic [7:0] bcd_dec(input logic [7:0] v);
    if (v[3:0] == 4'd0) return {v[7:4] - 4'd1, 4'd9};
    return {v[7:4], v[3:0] - 4'd1};
  endfunction

  state_t     state_q;
  logic [3:0] tens_q, tens_d;
  logic       tens_have_q, tens_have_d;
  logic [3:0] stab_q, stab_d;
  logic [7:0] prev_q, prev_d;
  logic [7:0] bcd_q;
  logic       value_vld_q, zero_q, seq_err_q, bad_glyph_q;

  logic [6:0] seg_n;
  glyph_t     g;
  logic       tens_s, ones_s, glyph_bad, frame_ok, accept, seq_ok, err_clr_w;
  logic [7:0] cand;

`ifdef SEG7_MON_ERR_CLR_EN
  assign err_clr_w = err_clr;
`else
  assign err_clr_w = 1'b0;
`endif

  always_comb begin
    seg_n       = SEG_ACTIVE_LOW ? ~seg : seg;
    g           = decode(seg_n);
    tens_s      = seg_valid & dig_sel;
    ones_s      = seg_valid & ~dig_sel & tens_have_q;
    glyph_bad   = (tens_s & g.invalid) | (ones_s & (g.invalid | g.blank));
    frame_ok    = ones_s & ~glyph_bad;
    cand        = {tens_q, g.digit};
    tens_have_d = tens_have_q;
    tens_d      = tens_q;
    stab_d      = stab_q;
    prev_d      = prev_q;

    // A blank tens glyph decodes with digit 0, giving leading-zero suppression
    if (tens_s && !g.invalid) begin
      tens_have_d = 1'b1;
      tens_d      = g.digit;
    end else if (tens_s || ones_s) begin
      tens_have_d = 1'b0;
    end

    if (glyph_bad) begin
      stab_d = 4'd0;
    end else if (frame_ok) begin
      prev_d = cand;
      if (cand != prev_q)
        stab_d = 4'd1;
      else if (stab_q < STAB_MAX)
        stab_d = stab_q + 4'd1;
    end

    accept = frame_ok && (stab_d == STAB_MAX) && ((cand != bcd_q) || (state_q == EMPTY));
    seq_ok = (cand == 8'h99) || (state_q == EMPTY) ||
             ((state_q == TRACK) && (cand == bcd_dec(bcd_q)));
  end

  always_ff @(posedge clkIn or posedge rst) begin
    if (rst) begin
      state_q     <= EMPTY;
      tens_q      <= 4'd0;
      tens_have_q <= 1'b0;
      stab_q      <= 4'd0;
      prev_q      <= 8'h00;
      bcd_q       <= 8'h00;
      value_vld_q <= 1'b0;
      zero_q      <= 1'b0;
      seq_err_q   <= 1'b0;
      bad_glyph_q <= 1'b0;
    end else begin
      tens_q      <= tens_d;
      tens_have_q <= tens_have_d;
      stab_q      <= stab_d;
      prev_q      <= prev_d;
      value_vld_q <= accept;
      // An error event in the same cycle as a clear keeps the flag set
      bad_glyph_q <= (bad_glyph_q & ~err_clr_w) | glyph_bad;
      seq_err_q   <= (seq_err_q & ~err_clr_w) | (accept & ~seq_ok);
      if (accept) begin
        bcd_q <= cand;
        case (state_q)
          EMPTY: begin
            state_q <= (cand == 8'h00) ? DONE : TRACK;
            zero_q  <= (cand == 8'h00);
          end
          TRACK: begin
            if (cand == 8'h00) begin
              state_q <= DONE;
              zero_q  <= 1'b1;
            end
          end
          DONE: begin
            if (cand == 8'h99) begin
              state_q <= TRACK;
              zero_q  <= 1'b0;
            end
          end
          default: begin
            state_q <= EMPTY;
            zero_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bcd       = bcd_q;
  assign value_vld = value_vld_q;
  assign zero      = zero_q;
  assign seq_err   = seq_err_q;
  assign bad_glyph = bad_glyph_q;

endmodule

// File: tb/tb_seg7_count_monitor.sv
// tb/tb_seg7_count_monitor.sv - vector table, hand sequences and random traffic against a frame-level model
module tb_seg7_count_monitor;

  localparam int S       = 2;
  localparam int M_EMPTY = 0;
  localparam int M_TRACK = 1;
  localparam int M_DONE  = 2;

  logic       clkIn = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] seg = 7'h00;
  logic       dig_sel = 1'b0;
  logic       seg_valid = 1'b0;
  logic       err_clr = 1'b0;
  logic [7:0] bcd;
  logic       value_vld, zero, seq_err, bad_glyph;

  always #5 clkIn = ~clkIn;

  seg7_count_monitor #(.SEG_ACTIVE_LOW(1'b0), .STABLE_FRAMES(S)) dut (
    .clkIn     (clkIn),
    .rst       (rst),
    .seg       (seg),
    .dig_sel   (dig_sel),
    .seg_valid (seg_valid),
`ifdef SEG7_MON_ERR_CLR_EN
    .err_clr   (err_clr),
`endif
    .bcd       (bcd),
    .value_vld (value_vld),
    .zero      (zero),
    .seq_err   (seq_err),
    .bad_glyph (bad_glyph)
  );

  int n_vec = 0;
  int n_err = 0;
  int vld_seen = 0;
  logic [6:0] glyph [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  // Frame-level reference: integers for values, a queue of recent candidates for stability
  int m_mode, m_bcd, m_tens;
  bit m_have, m_vld, m_seq, m_bad;
  int hist[$];

  typedef struct {
    bit v; bit s; logic [6:0] p;
    logic [7:0] e_bcd; bit e_vld; bit e_zero; bit e_seq; bit e_bad;
  } vec_t;
  vec_t tbl[$];

  function automatic vec_t mk(bit v, bit s, logic [6:0] p, logic [7:0] eb,
                              bit ev, bit ez, bit es, bit ebad);
    vec_t r;
    r.v = v; r.s = s; r.p = p;
    r.e_bcd = eb; r.e_vld = ev; r.e_zero = ez; r.e_seq = es; r.e_bad = ebad;
    return r;
  endfunction

  function automatic int decode_m(logic [6:0] p);
    if (p == 7'h00) return 10;
    for (int i = 0; i < 10; i++) if (glyph[i] == p) return i;
    return -1;
  endfunction

  function automatic logic [7:0] to_bcd(int v);
    return 8'(((v / 10) * 16) + (v % 10));
  endfunction

  function automatic bit stable_now(int c);
    if (hist.size() < S) return 1'b0;
    foreach (hist[i]) if (hist[i] != c) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    m_mode = M_EMPTY; m_bcd = 0; m_tens = 0;
    m_have = 0; m_vld = 0; m_seq = 0; m_bad = 0;
    hist.delete();
  endtask

  task automatic model_apply(bit v, bit s, logic [6:0] p, bit clr);
    bit ev_seq, ev_bad;
    int d, c;
    ev_seq = 0; ev_bad = 0;
    m_vld = 0;
    if (v) begin
      d = decode_m(p);
      if (s) begin
        if (d < 0) begin ev_bad = 1; m_have = 0; hist.delete(); end
        else begin m_have = 1; m_tens = (d == 10) ? 0 : d; end
      end else if (m_have) begin
        m_have = 0;
        if (d < 0 || d == 10) begin
          ev_bad = 1; hist.delete();
        end else begin
          c = m_tens * 10 + d;
          hist.push_back(c);
          if (hist.size() > S) void'(hist.pop_front());
          if (stable_now(c) && (c != m_bcd || m_mode == M_EMPTY)) begin
            if (!(c == 99 || m_mode == M_EMPTY || (m_mode == M_TRACK && c == m_bcd - 1))) ev_seq = 1;
            if (m_mode == M_EMPTY) m_mode = (c == 0) ? M_DONE : M_TRACK;
            else if (m_mode == M_TRACK && c == 0) m_mode = M_DONE;
            else if (m_mode == M_DONE && c == 99) m_mode = M_TRACK;
            m_bcd = c;
            m_vld = 1;
          end
        end
      end
    end
    m_seq = (m_seq && !clr) || ev_seq;
    m_bad = (m_bad && !clr) || ev_bad;
  endtask

  task automatic chk(string name, logic [7:0] act, logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_model(string tag);
    chk({tag, " bcd"}, bcd, to_bcd(m_bcd));
    chk({tag, " value_vld"}, {7'd0, value_vld}, {7'd0, m_vld});
    chk({tag, " zero"}, {7'd0, zero}, {7'd0, m_mode == M_DONE});
    chk({tag, " seq_err"}, {7'd0, seq_err}, {7'd0, m_seq});
    chk({tag, " bad_glyph"}, {7'd0, bad_glyph}, {7'd0, m_bad});
  endtask

  task automatic step(bit v, bit s, logic [6:0] p, bit clr);
    @(negedge clkIn);
    seg_valid = v; dig_sel = s; seg = p; err_clr = clr;
    @(posedge clkIn);
    #1;
    model_apply(v, s, p, clr);
    if (value_vld) vld_seen++;
    check_model("model");
    seg_valid = 1'b0; err_clr = 1'b0;
  endtask

  task automatic frame(int val, bit blank_tens);
    logic [6:0] tp;
    tp = (blank_tens && val < 10) ? 7'h00 : glyph[val / 10];
    step(1'b1, 1'b1, tp, 1'b0);
    step(1'b1, 1'b0, glyph[val % 10], 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clkIn);
    rst = 1'b1;
    model_reset();
    @(negedge clkIn);
    rst = 1'b0;
  endtask

  initial begin
    int tv, x, reps;
    bit clr_rand;

    model_reset();
    #1;
    chk("reset bcd", bcd, 8'h00);
    chk("reset flags", {4'd0, value_vld, zero, seq_err, bad_glyph}, 8'h00);
    @(negedge clkIn);
    rst = 1'b0;

    // Countdown, skip, bad glyph, lone ones sample, double tens sample
    tbl.push_back(mk(1, 1, glyph[9], 8'h00, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, glyph[9], 8'h00, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, glyph[9], 8'h00, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, glyph[9], 8'h99, 1, 0, 0, 0));
    tbl.push_back(mk(1, 1, glyph[9], 8'h99, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, glyph[8], 8'h99, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, glyph[9], 8'h99, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, glyph[8], 8'h98, 1, 0, 0, 0));
    tbl.push_back(mk(1, 1, glyph[9], 8'h98, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, glyph[7], 8'h98, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, glyph[9], 8'h98, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, glyph[7], 8'h97, 1, 0, 0, 0));
    tbl.push_back(mk(1, 1, glyph[9], 8'h97, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, glyph[5], 8'h97, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, glyph[9], 8'h97, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, glyph[5], 8'h95, 1, 0, 1, 0));
    tbl.push_back(mk(1, 1, glyph[9], 8'h95, 0, 0, 1, 0));
    tbl.push_back(mk(1, 0, 7'h01,    8'h95, 0, 0, 1, 1));
    tbl.push_back(mk(1, 0, glyph[4], 8'h95, 0, 0, 1, 1));
    tbl.push_back(mk(1, 1, glyph[9], 8'h95, 0, 0, 1, 1));
    tbl.push_back(mk(1, 0, glyph[4], 8'h95, 0, 0, 1, 1));
    tbl.push_back(mk(1, 1, glyph[9], 8'h95, 0, 0, 1, 1));
    tbl.push_back(mk(1, 0, glyph[4], 8'h94, 1, 0, 1, 1));
    tbl.push_back(mk(0, 0, 7'h00,    8'h94, 0, 0, 1, 1));
    tbl.push_back(mk(1, 1, glyph[3], 8'h94, 0, 0, 1, 1));
    tbl.push_back(mk(1, 1, glyph[9], 8'h94, 0, 0, 1, 1));
    tbl.push_back(mk(1, 0, glyph[3], 8'h94, 0, 0, 1, 1));
    tbl.push_back(mk(1, 1, glyph[9], 8'h94, 0, 0, 1, 1));
    tbl.push_back(mk(1, 0, glyph[3], 8'h93, 1, 0, 1, 1));

    foreach (tbl[i]) begin
      step(tbl[i].v, tbl[i].s, tbl[i].p, 1'b0);
      chk($sformatf("tbl%0d bcd", i), bcd, tbl[i].e_bcd);
      chk($sformatf("tbl%0d flags", i), {4'd0, value_vld, zero, seq_err, bad_glyph},
          {4'd0, tbl[i].e_vld, tbl[i].e_zero, tbl[i].e_seq, tbl[i].e_bad});
    end

    // Borrow through 10 -> 09 with blank tens, down to 00, then reload 99
    do_reset();
    for (int v = 11; v >= 0; v--) begin
      repeat (2) frame(v, 1'b1);
      if (v == 10) chk("borrow bcd 10", bcd, 8'h10);
      if (v == 9)  chk("borrow bcd 09", bcd, 8'h09);
    end
    chk("done bcd", bcd, 8'h00);
    chk("done zero", {7'd0, zero}, 8'd1);
    repeat (2) frame(99, 1'b0);
    chk("reload bcd", bcd, 8'h99);
    chk("reload zero", {7'd0, zero}, 8'd0);
    chk("reload seq_err", {7'd0, seq_err}, 8'd0);

    // Skip detection and optional clear
    do_reset();
    repeat (2) frame(55, 1'b0);
    repeat (2) frame(53, 1'b0);
    chk("skip bcd", bcd, 8'h53);
    chk("skip seq_err", {7'd0, seq_err}, 8'd1);
`ifdef SEG7_MON_ERR_CLR_EN
    step(1'b0, 1'b0, 7'h00, 1'b1);
    chk("err_clr seq_err", {7'd0, seq_err}, 8'd0);
    frame(51, 1'b0);
    step(1'b1, 1'b1, glyph[5], 1'b0);
    step(1'b1, 1'b0, glyph[1], 1'b1);
    chk("clr vs event seq_err", {7'd0, seq_err}, 8'd1);
`endif

    // Glitch rejection: a single differing frame must not disturb an accepted value
    do_reset();
    repeat (2) frame(42, 1'b0);
    frame(41, 1'b0);
    vld_seen = 0;
    repeat (2) frame(42, 1'b0);
    chk("glitch bcd", bcd, 8'h42);
    chk("glitch vld pulses", 8'(vld_seen), 8'd0);

    // Asynchronous reset between tens and ones samples
    step(1'b1, 1'b1, 7'h01, 1'b0);
    step(1'b1, 1'b1, glyph[9], 1'b0);
    @(negedge clkIn);
    #2 rst = 1'b1;
    #1;
    chk("async rst bcd", bcd, 8'h00);
    chk("async rst flags", {4'd0, value_vld, zero, seq_err, bad_glyph}, 8'h00);
    model_reset();
    @(negedge clkIn);
    rst = 1'b0;
    step(1'b1, 1'b0, glyph[9], 1'b0);
    repeat (2) frame(99, 1'b0);
    chk("post rst bcd", bcd, 8'h99);

    // Random traffic against the model
    do_reset();
    tv = 99;
    for (int it = 0; it < 1200; it++) begin
      int k;
      k = $urandom_range(0, 99);
`ifdef SEG7_MON_ERR_CLR_EN
      clr_rand = ($urandom_range(0, 3) == 0);
`else
      clr_rand = 1'b0;
`endif
      if (k < 5) begin
        step(1'b1, 1'($urandom_range(0, 1)), 7'($urandom), 1'b0);
      end else if (k < 9) begin
        step(1'b1, 1'b0, glyph[$urandom_range(0, 9)], 1'b0);
      end else if (k < 13) begin
        step(1'b0, 1'b0, 7'h00, clr_rand);
      end else begin
        x = (k < 20) ? int'($urandom_range(0, 99)) : tv;
        reps = $urandom_range(1, 3);
        for (int r = 0; r < reps; r++) begin
          step(1'b1, 1'b1, (x < 10 && $urandom_range(0, 1) == 1) ? 7'h00 : glyph[x / 10], 1'b0);
          if ($urandom_range(0, 4) == 0) step(1'b0, 1'b0, 7'h00, 1'b0);
          step(1'b1, 1'b0, glyph[x % 10], 1'b0);
        end
        if ($urandom_range(0, 9) < 6) tv = (tv == 0) ? 99 : tv - 1;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
